// File: rtl/rng_share_arbiter_if.sv
// Request/response bundle between the shared random-word source arbiter and its requesters.
// slave = arbiter side, master = requester/source side.
interface rng_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] rnd_in;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] rnd_out;
  logic             ready;
  logic             busy;
  logic             stuck_err;

  modport slave  (input  rnd_in, req, output ack, rnd_out, ready, busy, stuck_err);
  modport master (output rnd_in, req, input  ack, rnd_out, ready, busy, stuck_err);
endinterface

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of one LFSR word source: warm-up after reset, refresh gap after every
// grant attempt, and a sticky flag when the source keeps returning the same word.
module rng_share_arbiter #(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 16,
  parameter int STARTUP_CYCLES = 256,
  parameter int REFRESH_CYCLES = 16,
  parameter int MAX_REPEATS    = 3
) (
  input  logic CLK,
  input  logic reset_n,
  rng_share_arbiter_if.slave bus
);
  localparam int CMAX = (STARTUP_CYCLES > REFRESH_CYCLES) ? STARTUP_CYCLES : REFRESH_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam int PW   = $clog2(NREQ);
  localparam int RW   = $clog2(MAX_REPEATS + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_REFRESH} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ptr;
  logic [WIDTH-1:0]  last_word;
  logic [RW-1:0]     rep_cnt;
  logic [NREQ-1:0]   ack_q;
  logic [WIDTH-1:0]  rnd_q;
  logic              ready_q, busy_q, stuck_q;

  // Search order rotated so slot 0 is the current round-robin pointer
  logic [PW-1:0] idx [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_idx
    assign idx[g] = PW'((int'(ptr) + g) % NREQ);
  end

  logic          win_vld;
  logic [PW-1:0] win;
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && bus.req[idx[i]]) begin
        win_vld = 1'b1;
        win     = idx[i];
      end
    end
  end

  logic [PW-1:0] win_nxt;
  assign win_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_STARTUP;
      cnt       <= CW'(STARTUP_CYCLES - 1);
      ptr       <= '0;
      last_word <= '0;
      rep_cnt   <= '0;
      ack_q     <= '0;
      rnd_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      stuck_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        ST_STARTUP: begin
          if (cnt == '0) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (win_vld) begin
            // A repeated word is withheld: consumers never see the same sample twice
            if (bus.rnd_in != last_word) begin
              ack_q     <= NREQ'(1) << win;
              rnd_q     <= bus.rnd_in;
              last_word <= bus.rnd_in;
              ptr       <= win_nxt;
              rep_cnt   <= '0;
            end else begin
              if (rep_cnt != RW'(MAX_REPEATS)) rep_cnt <= rep_cnt + 1'b1;
              if (rep_cnt >= RW'(MAX_REPEATS - 1)) stuck_q <= 1'b1;
            end
            state  <= ST_REFRESH;
            cnt    <= CW'(REFRESH_CYCLES - 1);
            busy_q <= 1'b1;
          end
        end
        ST_REFRESH: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rnd_out   = rnd_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.stuck_err = stuck_q;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// Bench for rng_share_arbiter: directed scenarios plus random traffic, checked every cycle
// against a timeline model (eligible-time, rotating pointer, last delivered word).
module tb_rng_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SC = 256;
  localparam int RC = 16;
  localparam int MR = 3;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;

  rng_share_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

  rng_share_arbiter #(
    .NREQ(N), .WIDTH(W), .STARTUP_CYCLES(SC), .REFRESH_CYCLES(RC), .MAX_REPEATS(MR)
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference: cycles since reset, first cycle at which a request may be taken,
  // round-robin pointer, last delivered word, repeat count, expected outputs.
  int           cyc, elig, m_ptr, m_reps;
  logic [W-1:0] m_last, m_out;
  logic [N-1:0] m_ack;
  logic         m_stuck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(1, 65535));
  endfunction

  function automatic void m_reset();
    cyc = 0; elig = SC; m_ptr = 0; m_reps = 0;
    m_last = '0; m_out = '0; m_ack = '0; m_stuck = 1'b0;
  endfunction

  // One clock: drive inputs, predict, clock, compare all outputs.
  task automatic cyc1(input logic [N-1:0] r, input logic [W-1:0] d);
    bus.req = r;
    bus.rnd_in = d;
    m_ack = '0;
    if (cyc >= elig && r != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && ((r >> ((m_ptr + k) % N)) & N'(1)) != '0) w = (m_ptr + k) % N;
      if (d != m_last) begin
        m_ack = N'(1) << w;
        m_out = d; m_last = d; m_ptr = (w + 1) % N; m_reps = 0;
      end else begin
        if (m_reps < MR) m_reps++;
        if (m_reps == MR) m_stuck = 1'b1;
      end
      elig = cyc + RC + 1;
    end
    cyc++;
    @(posedge CLK); #1;
    chk("ack",       32'(bus.ack),       32'(m_ack));
    chk("rnd_out",   32'(bus.rnd_out),   32'(m_out));
    chk("ready",     32'(bus.ready),     32'(cyc >= SC));
    chk("busy",      32'(bus.busy),      32'(cyc < elig));
    chk("stuck_err", 32'(bus.stuck_err), 32'(m_stuck));
  endtask

  // Hold r until the arbiter is eligible, then present d on the accepting cycle.
  task automatic grant(input logic [N-1:0] r, input logic [W-1:0] d);
    int g;
    g = 0;
    while (cyc < elig && g < 200) begin
      cyc1(r, rnd());
      g++;
    end
    cyc1(r, d);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("rst_ack",   32'(bus.ack),       32'(0));
    chk("rst_rnd",   32'(bus.rnd_out),   32'(0));
    chk("rst_ready", 32'(bus.ready),     32'(0));
    chk("rst_busy",  32'(bus.busy),      32'(1));
    chk("rst_stuck", 32'(bus.stuck_err), 32'(0));
    bus.req = '0;
    bus.rnd_in = '0;
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d;
    logic [N-1:0] e;
    int t_prev;
    bus.req = '0;
    bus.rnd_in = '0;
    #12;
    do_reset();

    // Warm-up with a request held from cycle 0
    for (int i = 0; i < SC; i++) cyc1(4'b0001, rnd());
    chk("warm_ready", 32'(bus.ready), 32'(1));
    d = rnd();
    cyc1(4'b0001, d);
    chk("first_ack", 32'(bus.ack), 32'(4'b0001));
    chk("first_rnd", 32'(bus.rnd_out), 32'(d));
    t_prev = cyc;

    // All requesting: rotation and 17-cycle spacing; ends with ptr back at 0
    for (int k = 0; k < 11; k++) begin
      grant(4'b1111, rnd());
      e = N'(1) << ((k + 1) % N);
      chk("rr_ack", 32'(bus.ack), 32'(e));
      chk("rr_spacing", 32'(cyc - t_prev), 32'(RC + 1));
      t_prev = cyc;
    end

    // Lone requester moves the pointer past itself
    grant(4'b0100, rnd());
    chk("lone_ack", 32'(bus.ack), 32'(4'b0100));
    grant(4'b1001, rnd());
    chk("ptr3_ack", 32'(bus.ack), 32'(4'b1000));
    grant(4'b1001, rnd());
    chk("wrap_ack", 32'(bus.ack), 32'(4'b0001));

    // Stuck source
    grant(4'b0001, 16'hA5A5);
    chk("stk_first", 32'(bus.ack), 32'(4'b0001));
    chk("stk_rnd", 32'(bus.rnd_out), 32'(16'hA5A5));
    for (int k = 0; k < MR; k++) begin
      grant(4'b0001, 16'hA5A5);
      chk("stk_noack", 32'(bus.ack), 32'(0));
      chk("stk_rnd_hold", 32'(bus.rnd_out), 32'(16'hA5A5));
      chk("stk_flag", 32'(bus.stuck_err), 32'(k == MR - 1));
    end
    grant(4'b0001, 16'h1234);
    chk("stk_resume", 32'(bus.ack), 32'(4'b0001));
    chk("stk_sticky", 32'(bus.stuck_err), 32'(1));

    // Reset in the middle of a refresh gap (counter at 7)
    grant(4'b0010, rnd());
    while (cyc < elig - 8) cyc1(4'b0000, rnd());
    chk("pre_rst_busy", 32'(bus.busy), 32'(1));
    do_reset();
    for (int i = 0; i < SC; i++) cyc1(4'b0000, rnd());

    // All-zero word at the first grant is a repeat of the reset value
    grant(4'b0001, 16'h0000);
    chk("zero_noack", 32'(bus.ack), 32'(0));
    chk("zero_stuck", 32'(bus.stuck_err), 32'(0));
    grant(4'b0001, 16'h00C3);
    chk("zero_then_ack", 32'(bus.ack), 32'(4'b0001));
    chk("zero_then_rnd", 32'(bus.rnd_out), 32'(16'h00C3));

    // Random traffic with occasional repeated words
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 7) == 0) ? m_last : rnd();
      cyc1(N'($urandom_range(0, (1 << N) - 1)), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Shares one 16-bit randomized LFSR word source (metastability-seeded ring-oscillator LFSR) among NREQ requesters.
- Round-robin arbitration, with a startup warm-up after reset.
- After every delivered word, enforces a refresh gap so the LFSR has shifted fully before the next word is handed out.
- Health check: detects a stuck source (repeated word) and flags it.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, random word width, equals LFSR width
STARTUP_CYCLES, 256, cycles after reset before the first grant (entropy accumulation)
REFRESH_CYCLES, 16, cycles between grants; must be >= WIDTH
MAX_REPEATS, 3, consecutive repeated samples before stuck_err is set

Ports:
CLK  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
rnd_in  input  WIDTH  parallel output of the randomized LFSR
req  input  NREQ  per-requester level request, held until ack
ack  output  NREQ  one-hot, one-cycle pulse; rnd_out valid in that cycle
rnd_out  output  WIDTH  delivered word, held until the next grant
ready  output  1  high once startup warm-up completes
busy  output  1  high in STARTUP and REFRESH states
stuck_err  output  1  sticky; source judged stuck

Behaviour:
- Reset (async assert, sync release):
  - state=STARTUP, cnt=STARTUP_CYCLES-1, ptr=0, last_word=0, rep_cnt=0.
  - ack=0, rnd_out=0, ready=0, busy=1, stuck_err=0.
  - Reset mid-operation aborts any grant; no ack is emitted.
- STARTUP: cnt decrements each cycle; at cnt==0, next state IDLE and ready=1 (ready stays 1 until reset). STARTUP length is exactly STARTUP_CYCLES cycles.
- IDLE: if req==0, stay. Otherwise, in the same cycle:
  - winner = first set bit of req, searching ptr, ptr+1, ... mod NREQ.
  - Compare rnd_in with last_word.
  - Different: next cycle ack[winner]=1, rnd_out=rnd_in (sampled value), last_word=rnd_in, ptr=(winner+1) mod NREQ, rep_cnt=0.
  - Equal: no ack, rnd_out unchanged, rep_cnt+1 (saturating); when rep_cnt reaches MAX_REPEATS, stuck_err=1. ptr unchanged.
  - Either way: state=REFRESH, cnt=REFRESH_CYCLES-1.
- REFRESH: ack returns to 0 after its single cycle; cnt decrements; at cnt==0, next state IDLE.
- Latency: req sampled high in IDLE at cycle t gives ack at t+1. Minimum spacing between consecutive acks is REFRESH_CYCLES+1 cycles.
- Requests outside IDLE are ignored, not queued. A req dropped before grant is simply not served.
- A req still high in the cycle after its ack is treated as a new request.
- stuck_err does not block grants; it only flags. Only reset clears it.
- Because last_word resets to 0, an all-zero rnd_in at the first grant counts as a repeat. This is intended: all-zero is the LFSR lock-up state.
- Simultaneous requests: only the winner is served; the others wait through REFRESH.
- At most one ack bit is ever high, and ack is 0 whenever busy is 1 except during the first REFRESH cycle.

Test Plan:
- Reset, then req=4'b0001 held from cycle 0 -> ready=0 and no ack for 256 cycles; ready=1 at cycle 256; ack=4'b0001 one cycle after the first IDLE cycle, rnd_out equals rnd_in sampled the cycle before.
- After warm-up, req=4'b1111 held, rnd_in stepping -> acks in order 0001, 0010, 0100, 1000, 0001, spaced exactly 17 cycles; rnd_out changes only on ack cycles.
- req=4'b0100 only, ptr=0 -> ack=4'b0100, then ptr=3; next req=4'b1001 -> ack=4'b1000 before 4'b0001.
- rnd_in forced constant 16'hA5A5 with req=4'b0001 -> first ack delivers A5A5; next three grant attempts give no ack; stuck_err=1 after the third; restoring a changing rnd_in -> acks resume, stuck_err stays 1.
- reset_n asserted during REFRESH with cnt=7 -> all outputs go to reset values immediately; the full 256-cycle STARTUP is repeated before any ack.
- rnd_in=0 at the first post-startup grant -> no ack, rep_cnt=1; a nonzero rnd_in at the next IDLE -> ack delivered.
